// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one bit per clock, valid/ready on both sides.
// Optional `BIN2BCD_SATURATE_EN`: clamp the result to all nines when the input overflows.
module bin_to_bcd_serial #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_in_valid,
    output logic                  io_in_ready,
    input  logic [BIN_W-1:0]      io_in_bits,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [4*DIGITS-1:0]   io_out_bits,
    output logic                  io_out_overflow
);

    localparam int OUT_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_sticky;
    logic [OUT_W-1:0]   out_bits;
    logic               out_ovf;
    logic [BIN_W-1:0]   bin_sr;
    logic [OUT_W-1:0]   bcd_sr;

    logic [OUT_W-1:0]   bcd_adj;
    logic [OUT_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;
    logic               ovf_next;
    logic [OUT_W-1:0]   result;

    // Digits are adjusted independently; a 4-bit add of 3 to 5..9 never wraps.
    function automatic logic [OUT_W-1:0] add3_digits(input logic [OUT_W-1:0] v);
        logic [OUT_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef BIN2BCD_SATURATE_EN
    function automatic logic [OUT_W-1:0] saturate(input logic [OUT_W-1:0] v, input logic ovf);
        return ovf ? {DIGITS{4'h9}} : v;
    endfunction
`endif

    always_comb begin
        bcd_adj  = add3_digits(bcd_sr);
        bcd_next = {bcd_adj[OUT_W-2:0], bin_sr[BIN_W-1]};
        bin_next = {bin_sr[BIN_W-2:0], 1'b0};
        // The bit leaving the top digit means the value no longer fits in DIGITS digits.
        ovf_next = ovf_sticky | bcd_adj[OUT_W-1];
`ifdef BIN2BCD_SATURATE_EN
        result   = saturate(bcd_next, ovf_next);
`else
        result   = bcd_next;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_bits   <= '0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        state      <= SHIFT;
                        cnt        <= CNT_W'(BIN_W);
                        ovf_sticky <= 1'b0;
                    end
                end
                SHIFT: begin
                    cnt        <= cnt - CNT_W'(1);
                    ovf_sticky <= ovf_next;
                    if (cnt == CNT_W'(1)) begin
                        state    <= DONE;
                        out_bits <= result;
                        out_ovf  <= ovf_next;
                    end
                end
                DONE: begin
                    if (io_out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working shift registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge clock) begin
        if (state == IDLE && io_in_valid) begin
            bin_sr <= io_in_bits;
            bcd_sr <= '0;
        end else if (state == SHIFT) begin
            bin_sr <= bin_next;
            bcd_sr <= bcd_next;
        end
    end

    assign io_in_ready     = (state == IDLE);
    assign io_out_valid    = (state == DONE);
    assign io_out_bits     = out_bits;
    assign io_out_overflow = out_ovf;

endmodule

// File: doc/bin_to_bcd_serial.md
# bin_to_bcd_serial

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the 4-digit BCD parallel adder and produces packed BCD operands for it from plain binary values. Valid/ready handshakes are used on both the input and the output sides. Out-of-range inputs are flagged.

## Interface
Parameters:
- `BIN_W`, default 14. Binary input width; legal range 4..32.
- `DIGITS`, default 4. Number of BCD output digits; legal range 1..8. Output width is 4*DIGITS.

Ports:
- `clock`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `io_in_valid`  in  1  Input word presented.
- `io_in_ready`  out  1  Converter idle and able to accept.
- `io_in_bits`  in  BIN_W  Unsigned binary value.
- `io_out_valid`  out  1  Result available.
- `io_out_ready`  in  1  Consumer accepts result.
- `io_out_bits`  out  4*DIGITS  Packed BCD; digit 0 is in bits [3:0].
- `io_out_overflow`  out  1  Input exceeded 10^DIGITS − 1.

## Operation
- FSM states: IDLE, SHIFT, DONE. `io_in_ready` = (state==IDLE). `io_out_valid` = (state==DONE).
- IDLE, with `io_in_valid` high:
  - Load binary shift register with `io_in_bits`.
  - Clear BCD register and sticky overflow.
  - Load iteration counter with BIN_W.
  - Go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every BCD digit ≥5 gets +3 (4-bit add, no carry between digits).
  - Then shift {BCD, binary} left by 1.
  - The bit shifted out of the top digit ORs into sticky overflow.
  - Decrement counter. On the iteration where the counter reaches 0, go to DONE.
- DONE:
  - `io_out_bits` and `io_out_overflow` are held stable.
  - On `io_out_ready` high, go to IDLE.
  - Inputs are ignored while not in IDLE.
- Without saturation, the BCD register after BIN_W iterations equals input mod 10^DIGITS.
- Overflow is set iff input > 10^DIGITS − 1.
- Every digit of `io_out_bits` is always in the range 0..9.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, `io_in_ready`=1, `io_out_valid`=0, `io_out_bits`=0, `io_out_overflow`=0, counter=0.
- Reset mid-conversion aborts the conversion. No output is produced for that input.
- Input accepted at edge 0; `io_out_valid` rises after edge BIN_W. With defaults, 14 cycles.
- Output handshake at edge N; `io_in_ready` is high after edge N. The next input can be accepted at edge N+1.
- Minimum period per conversion: BIN_W+2 cycles.
- `io_in_valid` arriving in the same cycle as the output handshake is not accepted that cycle. The upstream block must hold it.
- `io_out_ready` held low: DONE persists indefinitely and the outputs do not change.
- `io_in_bits` is sampled only at the accept edge. Later changes to it have no effect.

## Configuration
- Macro `BIN2BCD_SATURATE_EN`.
- Defined: when overflow is 1, `io_out_bits` is forced to all digits 9 (0x9999 with defaults). `io_out_overflow` is still asserted.
- Undefined: `io_out_bits` is the modulo result (input mod 10^DIGITS) and `io_out_overflow` is asserted. There is no saturation logic.

## Test plan
- Input 0, `io_out_ready`=1 → after 14 cycles `io_out_bits`=0x0000, overflow=0; `io_in_ready` high on the following cycle.
- Input 9999 (0x270F) → `io_out_bits`=0x9999, overflow=0, `io_out_valid` exactly 14 cycles after accept.
- Input 1234 with `io_out_ready` low for 5 cycles after valid → 0x1234 held stable, `io_in_ready`=0 throughout; new `io_in_valid` pulses are ignored.
- Input 16383 → overflow=1. Output is 0x9999 with `BIN2BCD_SATURATE_EN` defined, 0x6383 without it.
- `reset` driven low 5 cycles into converting 5000 → immediately `io_out_valid`=0, `io_out_bits`=0, `io_in_ready`=1. After release, input 42 → 0x0042.
- Back-to-back inputs 10 and 9090 with `io_out_ready` tied high → results 0x0010 then 0x9090; the second is accepted one cycle after the first output handshake, giving a 16-cycle period.
